// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states and frame constants for the 16x-oversampled 8N1 UART
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = OVERSAMPLE / 2;
    localparam int DATA_BITS  = 8;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serialiser; busy drops in the last stop cycle so frames can abut
module uart_tx
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 tx,
    output logic                 busy
);

    tx_state_t            state, next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 last;
    logic                 load;

    assign last = (cnt == CNT_W'(OVERSAMPLE - 1));
    assign busy = !(state == TX_IDLE || (state == TX_STOP && last));
    assign load = start && !busy;

    always_comb begin
        next = state;
        if (load) begin
            next = TX_START;
        end else begin
            case (state)
                TX_START: if (last) next = TX_DATA;
                TX_DATA:  if (last && idx == IDX_W'(DATA_BITS - 1)) next = TX_STOP;
                TX_STOP:  if (last) next = TX_IDLE;
                default:  next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
        end else begin
            state <= next;
            if (load || next != state || state == TX_IDLE || last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                shreg <= tx_byte;
                idx   <= '0;
                tx    <= 1'b0;
            end else if (last) begin
                case (state)
                    TX_START: tx <= shreg[0];
                    TX_DATA: begin
                        if (next == TX_STOP) begin
                            tx <= 1'b1;
                        end else begin
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                            idx   <= idx + 1'b1;
                        end
                    end
                    default: tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_echo.sv
// rtl/uart_echo.sv - 8N1 receiver with optional echo transmitter (enabled by UART_ECHO_EN)
module uart_echo
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 b,
    output logic                 tx,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready
);

    rx_state_t            rx_state, rx_next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick_last;
    logic                 mid_start;
    logic                 accept;

    assign tick_last = (cnt == CNT_W'(OVERSAMPLE - 1));
    assign mid_start = (cnt == CNT_W'(HALF_BIT - 1));

    always_comb begin
        rx_next = rx_state;
        accept  = 1'b0;
        case (rx_state)
            IDLE:  if (!b) rx_next = START;
            START: if (mid_start) rx_next = b ? IDLE : DATA;
            DATA:  if (tick_last && idx == IDX_W'(DATA_BITS - 1)) rx_next = STOP;
            STOP: begin
                if (tick_last) begin
                    rx_next = IDLE;
                    accept  = b;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    // Counter restarts on every state change, so later samples land mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            data     <= '0;
            ready    <= 1'b0;
        end else begin
            rx_state <= rx_next;
            ready    <= accept;
            if (accept) data <= shreg;
            if (rx_state == IDLE || rx_next != rx_state || tick_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (rx_state == START) idx <= '0;
            if (rx_state == DATA && tick_last) begin
                shreg <= {b, shreg[DATA_BITS-1:1]};
                idx   <= idx + 1'b1;
            end
        end
    end

`ifdef UART_ECHO_EN
    logic                 tx_busy;
    logic                 tx_start;
    logic                 buf_full;
    logic [DATA_BITS-1:0] buf_byte;
    logic [DATA_BITS-1:0] tx_byte;

    assign tx_start = !tx_busy && (buf_full || ready);
    assign tx_byte  = buf_full ? buf_byte : data;

    // Buffered byte goes first; a new arrival in the same cycle takes its place.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_byte <= '0;
        end else if (ready && !(tx_start && !buf_full)) begin
            buf_full <= 1'b1;
            buf_byte <= data;
        end else if (tx_start) begin
            buf_full <= 1'b0;
        end
    end

    uart_tx u_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (tx_start),
        .tx_byte (tx_byte),
        .tx      (tx),
        .busy    (tx_busy)
    );
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_echo.sv
// tb/tb_uart_echo.sv - randomized scoreboard bench for uart_echo (echo checks with UART_ECHO_EN)
module tb_uart_echo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b = 1'b1;
    logic       tx;
    logic       ready;
    logic [7:0] data;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] v;
        int         cyc;
    } ev_t;

    ev_t        rx_q[$];
    ev_t        arr_q[$];
    ev_t        pend_ev;
    bit         pend = 1'b0;
    int         tx_free = 0;
    bit         tx_low_seen = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_echo dut (
        .clk   (clk),
        .reset (reset),
        .b     (b),
        .tx    (tx),
        .data  (data),
        .ready (ready)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            ev_t e;
            check("ready_gap", {31'd0, prev_ready}, 0);
            if (rx_q.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                e = rx_q.pop_front();
                check("rx_data", {24'd0, data}, {24'd0, e.v});
                check("rx_time", cyc, e.cyc);
            end
        end
        prev_ready <= ready;
    end

`ifdef UART_ECHO_EN
    // One transmitter plus a one-byte buffer whose contents a later arrival replaces.
    task automatic expect_echo(output bit ok, output ev_t e);
        ev_t a;
        ok = 1'b0;
        e  = '{8'h00, 0};
        if (!pend) begin
            if (arr_q.size() == 0) return;
            a = arr_q.pop_front();
            if (a.cyc + 1 >= tx_free) begin
                e.v     = a.v;
                e.cyc   = a.cyc + 1;
                tx_free = a.cyc + 161;
                ok      = 1'b1;
                return;
            end
            pend    = 1'b1;
            pend_ev = a;
        end
        while (arr_q.size() > 0 && arr_q[0].cyc + 1 < tx_free) pend_ev = arr_q.pop_front();
        e.v     = pend_ev.v;
        e.cyc   = tx_free;
        pend    = 1'b0;
        tx_free = tx_free + 160;
        ok      = 1'b1;
    endtask

    initial begin
        int         f;
        logic [9:0] fr;
        ev_t        e;
        bit         ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b0) begin
                f = cyc;
                repeat (8) @(negedge clk);
                fr[0] = tx;
                for (int k = 1; k < 10; k++) begin
                    repeat (16) @(negedge clk);
                    fr[k] = tx;
                end
                expect_echo(ok, e);
                if (!ok) begin
                    check("unexpected_echo", 1, 0);
                end else begin
                    check("echo_data", {24'd0, fr[8:1]}, {24'd0, e.v});
                    check("echo_time", f, e.cyc);
                    check("echo_frame", {30'd0, fr[9], fr[0]}, 2'b10);
                end
            end
        end
    end
`else
    always @(negedge clk) if (tx !== 1'b1) tx_low_seen <= 1'b1;
`endif

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        rx_q.delete();
        arr_q.delete();
        pend      = 1'b0;
        tx_free   = 0;
        last_good = 8'h00;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        check({tag, "_tx"}, {31'd0, tx}, 1);
        check({tag, "_ready"}, {31'd0, ready}, 0);
        check({tag, "_data"}, {24'd0, data}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string name);
        @(negedge clk);
        check(name, {24'd0, data}, {24'd0, last_good});
        @(posedge clk);
        #1;
    endtask

    // Each reply is due 153 cycles after the start bit is driven.
    task automatic send_frame(input logic [7:0] v, input bit good, input int stop_hold);
        logic [9:0] bits;
        int         n;
        bits = {good, v, 1'b0};
        n    = cyc;
        if (good) begin
            rx_q.push_back(ev_t'{v, n + 153});
            arr_q.push_back(ev_t'{v, n + 153});
            last_good = v;
        end
        for (int i = 0; i < 10; i++) begin
            b = bits[i];
            idle(i == 9 ? stop_hold : 16);
        end
        b = 1'b1;
    endtask

    task automatic abort_frame(input logic [7:0] v);
        logic [9:0] bits;
        bits = {1'b1, v, 1'b0};
        for (int i = 0; i < 4; i++) begin
            b = bits[i];
            idle(16);
        end
        b = bits[4];
        idle(8);
        b = 1'b1;
        do_reset("midreset");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        bit         good;
        @(posedge clk);
        #1;
        do_reset("reset");
        idle(5);

        send_frame(8'hBA, 1'b1, 16);
        idle(4);
        check_data("data_ba");

        send_frame(8'h90, 1'b0, 16);
        idle(20);
        check_data("data_hold_ferr");

        b = 1'b0;
        idle(4);
        b = 1'b1;
        idle(20);
        check_data("data_after_glitch");
        send_frame(8'h55, 1'b1, 16);
        idle(2);
        check_data("data_55");

        send_frame(8'hA1, 1'b1, 16);
        send_frame(8'h3C, 1'b1, 16);
        idle(2);
        check_data("data_b2b");

        idle(400);
        abort_frame(8'hA5);
        idle(20);
        send_frame(8'hA5, 1'b1, 16);
        idle(2);
        check_data("data_a5");

        for (int i = 0; i < 40; i++) begin
            v    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 9) < 8);
            send_frame(v, good, good ? int'($urandom_range(9, 16)) : 16);
            idle(good ? int'($urandom_range(0, 4)) : 20);
            if ($urandom_range(0, 3) == 0) check_data("data_rand");
        end

        idle(600);
        check("rx_leftover", rx_q.size(), 0);
`ifdef UART_ECHO_EN
        check("echo_leftover", arr_q.size() + int'(pend), 0);
`else
        check("tx_idle_high", {31'd0, tx_low_seen}, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
